rr_encoder: RTL and testbench
=============================

RR_ENCODER -- requirements
Module: rr_encoder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5, the number of request lines; legal range 2..32.
REQ-002 SHALL have localparam IDX_W = $clog2(NUM_INPUTS), the width of the grant index.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_request, input, NUM_INPUTS bits: request vector; bit k high means source k requests service.
REQ-006 SHALL have port i_ready, input, 1 bit: consumer accepts the current grant.
REQ-007 SHALL have port o_valid, output, 1 bit: o_index holds a valid grant.
REQ-008 SHALL have port o_index, output, IDX_W bits: binary index of the granted source.
REQ-009 SHALL have port o_grant_onehot, output, NUM_INPUTS bits; it is present only under RR_ENCODER_ONEHOT_EN.

Function
REQ-010 SHALL be the inverse of the team's demux: it converts a multi-hot request vector to one binary index, registered, with a valid/ready handshake.
REQ-011 SHALL define "accept" as a cycle in which o_valid=1 and i_ready=1.
REQ-012 SHALL define the block as "open" in a cycle when o_valid=0 or an accept occurs.
REQ-013 SHALL, when open and i_request is non-zero, select the first set bit at or after the internal pointer ptr, searching upward with wrap from NUM_INPUTS-1 to 0.
REQ-014 SHALL, on such a selection, set o_valid=1 and o_index=selected index on the next edge, and set ptr to the selected index+1; ptr wraps from NUM_INPUTS-1 to 0.
REQ-015 SHALL, when open and i_request is all-zero, clear o_valid on the next edge; o_index and ptr keep their values.
REQ-016 SHALL, when o_valid=1 and i_ready=0, hold o_valid, o_index and ptr stable; i_request is ignored, including deassertion of the granted bit.
REQ-017 SHALL have a latency of exactly 1 cycle from sampled request to o_valid; back-to-back accepts sustain one grant per cycle.
REQ-018 SHALL ensure that no requester with a continuously asserted bit waits more than NUM_INPUTS-1 grants (fairness).
REQ-019 SHALL produce o_index only in the range 0..NUM_INPUTS-1; index values at or above NUM_INPUTS never appear, even when NUM_INPUTS is not a power of two.
REQ-020 SHALL ignore i_ready while o_valid=0.

Reset
REQ-021 SHALL, while i_rst=1 at a clock edge, set o_valid=0, o_index=0 and ptr=0; any held grant is discarded without an accept.
REQ-022 SHALL, on the first edge with i_rst=0, treat the block as open and sample i_request normally.

Configuration
REQ-023 SHALL, with macro RR_ENCODER_ONEHOT_EN defined, add o_grant_onehot, registered alongside o_index, equal to (1 << o_index) when o_valid=1 and all-zero otherwise; its reset value is 0.
REQ-024 SHALL, without RR_ENCODER_ONEHOT_EN, omit the port and its register; all other behaviour is identical.

Structure
REQ-025 SHALL place in the shared processor package a function returning IDX_W for a given count, shared with demux.
REQ-026 SHALL place in the same shared package a round-robin "next set bit from pointer" function.
REQ-027 SHALL contain exactly one sub-module, rr_pick: a combinational block taking i_request and ptr and returning found plus index.
REQ-028 SHALL keep all registers (o_valid, o_index, ptr and the optional one-hot register) in rr_encoder.

Verification (NUM_INPUTS=5)
REQ-029 SHALL cover reset: i_rst=1 for 2 cycles with i_request=5'b11111 -> o_valid=0, o_index=0; on the first cycle after release -> o_valid=1, o_index=0.
REQ-030 SHALL cover rotation: i_request=5'b10101, i_ready=1 held -> o_index sequence 0,2,4,0,2 on consecutive cycles, o_valid continuously 1.
REQ-031 SHALL cover backpressure: grant o_index=2 with i_ready=0 for 3 cycles while i_request changes to 5'b00001 -> o_index stays 2; after i_ready=1 -> next o_index=0.
REQ-032 SHALL cover wrap and empty: ptr=4 (after granting 3), i_request=5'b00001 -> o_index=0; then i_request=0 with i_ready=1 -> o_valid=0 next cycle.
REQ-033 SHALL cover reset mid-operation: o_valid=1, o_index=3, i_ready=0, then i_rst=1 for one cycle -> o_valid=0, and ptr=0 as shown by the next grant from 5'b11000 being 3.
REQ-034 SHALL cover the macro: with RR_ENCODER_ONEHOT_EN, o_index=4 -> o_grant_onehot=5'b10000; with o_valid=0 -> o_grant_onehot=5'b00000.

Source files
------------

// File: rtl/rr_encoder_pkg.sv
// Shared helpers for the request encoder and demux: index-width sizing and
// the round-robin "next set bit from pointer" search.
package rr_encoder_pkg;

  localparam int unsigned MAX_INPUTS = 32;
  localparam int unsigned PTR_W      = 5;
  localparam int unsigned CNT_W      = 6;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // Number of bits needed to hold a binary index for 'count' items.
  function automatic int unsigned idx_width(input int unsigned count);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(count)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // First set bit of req at or after ptr, wrapping at n; ptr must be below n.
  function automatic rr_pick_t rr_next_set(
    input logic [MAX_INPUTS-1:0] req,
    input logic [PTR_W-1:0]      ptr,
    input logic [CNT_W-1:0]      n
  );
    rr_pick_t         res;
    logic [CNT_W-1:0] pos;
    res.found = 1'b0;
    res.idx   = {PTR_W{1'b0}};
    for (int k = 0; k < MAX_INPUTS; k++) begin
      pos = {1'b0, ptr} + CNT_W'(k);
      if (pos >= n) begin
        pos = pos - n;
      end else begin
        pos = pos;
      end
      if (!res.found && (CNT_W'(k) < n) && req[pos[PTR_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[PTR_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting source at or after ptr.
module rr_pick
  import rr_encoder_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  localparam int unsigned IDX_W     = idx_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] i_request,
  input  logic [IDX_W-1:0]      i_ptr,
  output logic                  o_found,
  output logic [IDX_W-1:0]      o_index
);

  logic [MAX_INPUTS-1:0] req_ext_s;
  logic [PTR_W-1:0]      ptr_ext_s;
  rr_pick_t              pick_s;

  always_comb begin
    req_ext_s = MAX_INPUTS'(i_request);
    ptr_ext_s = PTR_W'(i_ptr);
    pick_s    = rr_next_set(req_ext_s, ptr_ext_s, CNT_W'(NUM_INPUTS));
    o_found   = pick_s.found;
    o_index   = IDX_W'(pick_s.idx);
  end

endmodule

// File: rtl/rr_encoder.sv
// Round-robin request encoder: multi-hot request vector to a registered binary
// grant index with valid/ready. RR_ENCODER_ONEHOT_EN adds a one-hot grant port.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  localparam int unsigned IDX_W     = $clog2(NUM_INPUTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_INPUTS-1:0] i_request,
  input  logic                  i_ready,
  output logic                  o_valid,
`ifdef RR_ENCODER_ONEHOT_EN
  output logic [NUM_INPUTS-1:0] o_grant_onehot,
`endif
  output logic [IDX_W-1:0]      o_index
);

  logic                  valid_q, valid_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [IDX_W-1:0]      ptr_q,   ptr_d;
  logic                  open_s;
  logic                  found_s;
  logic [IDX_W-1:0]      pick_index_s;

  rr_pick #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_pick (
    .i_request (i_request),
    .i_ptr     (ptr_q),
    .o_found   (found_s),
    .o_index   (pick_index_s)
  );

  // A held grant blocks new selections until it is accepted.
  always_comb begin
    open_s  = !valid_q || i_ready;
    valid_d = valid_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    if (open_s) begin
      if (found_s) begin
        valid_d = 1'b1;
        index_d = pick_index_s;
        if (pick_index_s == IDX_W'(NUM_INPUTS - 1)) begin
          ptr_d = {IDX_W{1'b0}};
        end else begin
          ptr_d = pick_index_s + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      index_q <= {IDX_W{1'b0}};
      ptr_q   <= {IDX_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_ENCODER_ONEHOT_EN
  logic [NUM_INPUTS-1:0] onehot_q, onehot_d;

  always_comb begin
    onehot_d = onehot_q;
    if (open_s) begin
      if (found_s) begin
        onehot_d = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << pick_index_s;
      end else begin
        onehot_d = {NUM_INPUTS{1'b0}};
      end
    end else begin
      onehot_d = onehot_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      onehot_q <= {NUM_INPUTS{1'b0}};
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign o_grant_onehot = onehot_q;
`endif

  assign o_valid = valid_q;
  assign o_index = index_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Scoreboard bench for rr_encoder (NUM_INPUTS=5): directed scenarios plus
// random traffic against a behavioural round-robin model.
module tb_rr_encoder;

  localparam int N  = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          rdy = 1'b0;
  logic          v;
  logic [IW-1:0] idx;
`ifdef RR_ENCODER_ONEHOT_EN
  logic [N-1:0]  oh;
`endif

  always #5 clk = ~clk;

  rr_encoder #(.NUM_INPUTS(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_request      (req),
    .i_ready        (rdy),
    .o_valid        (v),
`ifdef RR_ENCODER_ONEHOT_EN
    .o_grant_onehot (oh),
`endif
    .o_index        (idx)
  );

  typedef struct {
    bit            v;
    logic [IW-1:0] idx;
    logic [N-1:0]  oh;
    int            sv;
    int            si;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;

  // One clock of stimulus; the model predicts the outputs after the next edge.
  // sv/si >= 0 add a spot check against a hand-derived constant.
  task automatic cycle(input bit r, input logic [N-1:0] rq, input bit rd,
                       input int sv = -1, input int si = -1);
    exp_t e;
    int   pick;
    @(negedge clk);
    rst = r;
    req = rq;
    rdy = rd;
    if (r) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (!m_valid || rd) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && rq[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_idx   = pick;
        m_ptr   = (pick + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    e.v   = m_valid;
    e.idx = IW'(m_idx);
    e.oh  = m_valid ? N'(1 << m_idx) : '0;
    e.sv  = sv;
    e.si  = si;
    q.push_back(e);
  endtask

  // Monitor: compares one expected entry per clock, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (v !== e.v || idx !== e.idx) begin
          n_bad++;
          $display("FAIL model t=%0t: got v=%0b idx=%0d, want v=%0b idx=%0d",
                   $time, v, idx, e.v, e.idx);
        end
        if (e.sv >= 0) begin
          n_vec++;
          if (v !== e.sv[0] || (e.si >= 0 && idx !== IW'(e.si))) begin
            n_bad++;
            $display("FAIL spot t=%0t: got v=%0b idx=%0d, want v=%0d idx=%0d",
                     $time, v, idx, e.sv, e.si);
          end
        end
`ifdef RR_ENCODER_ONEHOT_EN
        n_vec++;
        if (oh !== e.oh) begin
          n_bad++;
          $display("FAIL onehot t=%0t: got %b, want %b", $time, oh, e.oh);
        end
        if (e.sv == 1 && e.si == 4 && oh !== 5'b10000) begin
          n_bad++;
          $display("FAIL onehot_spot4 t=%0t: got %b, want 10000", $time, oh);
        end
        if (e.sv == 0 && oh !== 5'b00000) begin
          n_bad++;
          $display("FAIL onehot_spot_idle t=%0t: got %b, want 00000", $time, oh);
        end
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    bit           r;
    bit           rd;

    // Reset held two cycles with all requests, then first grant.
    cycle(1'b1, 5'b11111, 1'b0, 0, 0);
    cycle(1'b1, 5'b11111, 1'b0, 0, 0);
    cycle(1'b0, 5'b11111, 1'b0, 1, 0);

    // Rotation across sparse requests.
    cycle(1'b1, 5'b00000, 1'b0, 0, 0);
    cycle(1'b0, 5'b10101, 1'b1, 1, 0);
    cycle(1'b0, 5'b10101, 1'b1, 1, 2);
    cycle(1'b0, 5'b10101, 1'b1, 1, 4);
    cycle(1'b0, 5'b10101, 1'b1, 1, 0);
    cycle(1'b0, 5'b10101, 1'b1, 1, 2);

    // Backpressure holds grant 2 while requests change.
    cycle(1'b1, 5'b00000, 1'b0, 0, 0);
    cycle(1'b0, 5'b00100, 1'b0, 1, 2);
    cycle(1'b0, 5'b00001, 1'b0, 1, 2);
    cycle(1'b0, 5'b00001, 1'b0, 1, 2);
    cycle(1'b0, 5'b00001, 1'b0, 1, 2);
    cycle(1'b0, 5'b00001, 1'b1, 1, 0);

    // Pointer wrap, then empty request drops valid.
    cycle(1'b1, 5'b00000, 1'b0, 0, 0);
    cycle(1'b0, 5'b01000, 1'b1, 1, 3);
    cycle(1'b0, 5'b00001, 1'b1, 1, 0);
    cycle(1'b0, 5'b00000, 1'b1, 0, 0);

    // Reset while a grant is held resets the pointer.
    cycle(1'b1, 5'b00000, 1'b0, 0, 0);
    cycle(1'b0, 5'b01000, 1'b0, 1, 3);
    cycle(1'b1, 5'b01000, 1'b0, 0, 0);
    cycle(1'b0, 5'b11000, 1'b1, 1, 3);

    // Grant of the top index, then idle.
    cycle(1'b1, 5'b00000, 1'b0, 0, 0);
    cycle(1'b0, 5'b10000, 1'b1, 1, 4);
    cycle(1'b0, 5'b00000, 1'b1, 0, 4);

    // Random traffic with occasional resets and idle request vectors.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 5'b00000 : N'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      cycle(r, rq, rd);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
